// File: rtl/shift_sequencer_pkg.sv
// Shared types and default widths for the shift sequencer block.
// SHIFT_SEQ_PARITY_EN adds the PARITY state (one extra bit period after the data bits).
package shift_seq_pkg;

  localparam int DEF_CNT_BITS = 4;
  localparam int DEF_PER_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
`ifdef SHIFT_SEQ_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Handshake/control bundle between a frame requester (master) and the sequencer (slave).
// parity_slot exists only when SHIFT_SEQ_PARITY_EN is defined.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_PER_BITS = DEF_PER_BITS
);

  logic                    start;
  logic                    abort;
  logic [NUM_CNT_BITS-1:0] frame_len;
  logic [NUM_PER_BITS-1:0] bit_period;
  logic                    load_enable;
  logic                    shift_enable;
  logic                    busy;
  logic                    done;
  logic [NUM_CNT_BITS-1:0] bit_count;
`ifdef SHIFT_SEQ_PARITY_EN
  logic                    parity_slot;
`endif

  modport master (
    output start, abort, frame_len, bit_period,
    input  load_enable, shift_enable, busy, done, bit_count
`ifdef SHIFT_SEQ_PARITY_EN
    , input parity_slot
`endif
  );

  modport slave (
    input  start, abort, frame_len, bit_period,
    output load_enable, shift_enable, busy, done, bit_count
`ifdef SHIFT_SEQ_PARITY_EN
    , output parity_slot
`endif
  );

endinterface

// File: rtl/shift_sequencer_period_counter.sv
// Bit-period counter: counts 1..rollover_val while enabled, then restarts at 1.
// rollover_flag is high for the whole cycle in which count_out equals rollover_val.
module period_counter
  import shift_seq_pkg::*;
#(
  parameter int NUM_BITS = DEF_PER_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= NUM_BITS'(1);
      end else begin
        count_out <= count_out + NUM_BITS'(1);
      end
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/shift_sequencer.sv
// Frame sequencer: one load strobe, then one shift strobe per bit period until frame_len bits are out.
// SHIFT_SEQ_PARITY_EN appends one parity bit period flagged by parity_slot before DONE.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_PER_BITS = DEF_PER_BITS
) (
  input  logic             clk,
  input  logic             n_rst,
  shift_sequencer_if.slave bus
);

  state_t                  state;
  logic [NUM_CNT_BITS-1:0] len_q;
  logic [NUM_PER_BITS-1:0] per_q;
  logic [NUM_CNT_BITS-1:0] bit_count_q;
  logic [NUM_CNT_BITS-1:0] cnt_next;
  logic [NUM_PER_BITS-1:0] rollover_val;
  logic [NUM_PER_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    period_tick;
  logic                    shift_state;
  logic                    clear;
  logic                    count_enable;
  logic                    shift;

  // A latched period of 0 behaves as 1: one shift per clock.
  assign rollover_val = (per_q == '0) ? NUM_PER_BITS'(1) : per_q;
  assign cnt_next     = bit_count_q + NUM_CNT_BITS'(1);

`ifdef SHIFT_SEQ_PARITY_EN
  assign shift_state = (state == WAIT) || (state == PARITY);
`else
  assign shift_state = (state == WAIT);
`endif

  assign count_enable = (state == LOAD) || shift_state;
  assign clear        = !count_enable || bus.abort;
  // A freshly cleared counter reads 0 and must never be taken as a period boundary.
  assign period_tick  = rollover_flag && (count_out != '0);
  assign shift        = shift_state && period_tick;

  period_counter #(.NUM_BITS(NUM_PER_BITS)) u_period_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (count_enable),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      len_q       <= '0;
      per_q       <= '0;
      bit_count_q <= '0;
    end else if ((state != IDLE) && bus.abort) begin
      state       <= IDLE;
      bit_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort && (bus.frame_len != '0)) begin
            state       <= LOAD;
            len_q       <= bus.frame_len;
            per_q       <= bus.bit_period;
            bit_count_q <= '0;
          end
        end
        LOAD: state <= WAIT;
        WAIT: begin
          if (shift) begin
            bit_count_q <= cnt_next;
            if (cnt_next == len_q) begin
`ifdef SHIFT_SEQ_PARITY_EN
              state <= PARITY;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef SHIFT_SEQ_PARITY_EN
        PARITY: if (shift) state <= DONE;
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_enable  = (state == LOAD);
  assign bus.shift_enable = shift;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.bit_count    = bit_count_q;
`ifdef SHIFT_SEQ_PARITY_EN
  assign bus.parity_slot  = (state == PARITY) && period_tick;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: frame timing, zero-length/zero-period cases, abort, async reset.
module tb_shift_sequencer;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame model: LOAD in cycle 1, data shifts at 1+k*P, optional parity shift, then DONE.
  task automatic run_frame(input int f, input int p);
    int pe, last, dn, bc;
    pe = (p == 0) ? 1 : p;
`ifdef SHIFT_SEQ_PARITY_EN
    last = (f + 1) * pe + 1;
`else
    last = f * pe + 1;
`endif
    dn = last + 1;
    bus.frame_len  = f[3:0];
    bus.bit_period = p[7:0];
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= dn + 1; c++) begin
      bc = (c < 2) ? 0 : (c - 2) / pe;
      if (bc > f) bc = f;
      chk($sformatf("load_c%0d", c),  32'(bus.load_enable),  32'(c == 1));
      chk($sformatf("shift_c%0d", c), 32'(bus.shift_enable),
          32'((c > 1) && (c <= last) && ((c - 1) % pe == 0)));
      chk($sformatf("done_c%0d", c),  32'(bus.done), 32'(c == dn));
      chk($sformatf("busy_c%0d", c),  32'(bus.busy), 32'(c <= dn));
      chk($sformatf("bcnt_c%0d", c),  32'(bus.bit_count), 32'(bc));
`ifdef SHIFT_SEQ_PARITY_EN
      chk($sformatf("par_c%0d", c),   32'(bus.parity_slot), 32'(c == last));
`endif
      // Inputs changing mid-frame, and a stray start, must not disturb the frame.
      if (dn > 10 && c == 3) begin
        bus.frame_len  = 4'd1;
        bus.bit_period = 8'd1;
      end
      bus.start = (dn > 10 && c == 6);
      step();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    n_rst          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.frame_len  = '0;
    bus.bit_period = '0;
    #1;
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_load",  32'(bus.load_enable), 32'd0);
    chk("rst_shift", 32'(bus.shift_enable), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_bcnt",  32'(bus.bit_count), 32'd0);
    #11 n_rst = 1'b1;
    step();

    // Nominal frame: 8 bits, 4 clocks per bit
    run_frame(8, 4);
    // Zero period means one shift per cycle
    run_frame(3, 0);

    // Zero-length request is ignored
    bus.frame_len = 4'd0;
    bus.bit_period = 8'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("zlen_load", 32'(bus.load_enable), 32'd0);
    chk("zlen_busy", 32'(bus.busy), 32'd0);
    step();
    chk("zlen_busy2", 32'(bus.busy), 32'd0);

    // Abort in cycle 10 of the nominal frame
    bus.frame_len = 4'd8;
    bus.bit_period = 8'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abt_c10_busy", 32'(bus.busy), 32'd1);
    chk("abt_c10_bcnt", 32'(bus.bit_count), 32'd2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abt_c11_busy",  32'(bus.busy), 32'd0);
    chk("abt_c11_bcnt",  32'(bus.bit_count), 32'd0);
    chk("abt_c11_done",  32'(bus.done), 32'd0);
    chk("abt_c11_shift", 32'(bus.shift_enable), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (bus.done || bus.busy) seen++;
        step();
      end
      chk("abt_quiet", 32'(seen), 32'd0);
    end
    bus.frame_len = 4'd2;
    bus.bit_period = 8'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_load", 32'(bus.load_enable), 32'd1);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    step();
    chk("abt_load_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    step();
    chk("abt_start_load", 32'(bus.load_enable), 32'd0);
    chk("abt_start_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();
    chk("abt_start_busy2", 32'(bus.busy), 32'd0);

    // Asynchronous reset in a shift cycle of WAIT
    bus.frame_len = 4'd8;
    bus.bit_period = 8'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_shift", 32'(bus.shift_enable), 32'd1);
    chk("pre_rst_busy",  32'(bus.busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_shift", 32'(bus.shift_enable), 32'd0);
    chk("arst_load",  32'(bus.load_enable), 32'd0);
    chk("arst_done",  32'(bus.done), 32'd0);
    chk("arst_bcnt",  32'(bus.bit_count), 32'd0);
    #2 n_rst = 1'b1;
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, width of frame_len and bit_count.
REQ-002 SHALL have parameter NUM_PER_BITS, default 8, width of bit_period.
REQ-003 SHALL have clk  input  1  system clock; one clock domain only.
REQ-004 SHALL have n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have start  input  1  request to send one frame; sampled only in IDLE.
REQ-006 SHALL have abort  input  1  synchronous cancel of the frame in progress.
REQ-007 SHALL have frame_len  input  NUM_CNT_BITS  number of data bits per frame; latched at start acceptance.
REQ-008 SHALL have bit_period  input  NUM_PER_BITS  clocks per bit; latched at start acceptance.
REQ-009 SHALL have load_enable  output  1  one-cycle parallel-load strobe to the shift register.
REQ-010 SHALL have shift_enable  output  1  one-cycle shift strobe to the shift register.
REQ-011 SHALL have busy  output  1  high in every state except IDLE.
REQ-012 SHALL have done  output  1  one-cycle pulse at frame completion.
REQ-013 SHALL have bit_count  output  NUM_CNT_BITS  number of shifts issued in the current frame.

Function
REQ-014 SHALL implement states IDLE, LOAD, WAIT, DONE (plus PARITY, per REQ-027).
REQ-015 IDLE -> LOAD SHALL occur on start=1 with frame_len!=0; start with frame_len==0 SHALL be ignored.
REQ-016 LOAD SHALL last exactly one cycle with load_enable=1, then go to WAIT.
REQ-017 In WAIT, the period counter SHALL count 1,2,... and shift_enable SHALL be 1 in the cycle where it equals the latched period; the counter then restarts at 1.
REQ-018 A latched bit_period of 0 SHALL be treated as 1, giving one shift per cycle.
REQ-019 Each shift_enable SHALL increment bit_count; bit_count SHALL be 0 in LOAD.
REQ-020 The shift that makes bit_count equal the latched frame_len SHALL move WAIT -> DONE.
REQ-021 DONE SHALL last one cycle with done=1, then go to IDLE; bit_count SHALL hold its final value until the next LOAD.
REQ-022 start while busy=1 SHALL be ignored; frame_len and bit_period changes while busy SHALL have no effect.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and both counters cleared.
REQ-024 If abort and start are both 1 in IDLE, abort SHALL win and no frame SHALL start.
REQ-025 load_enable and shift_enable SHALL never be high in the same cycle.

Reset
REQ-026 With n_rst=0: state=IDLE, both counters=0, latched values=0; all outputs=0 immediately, independent of clk, including mid-frame.

Configuration
REQ-027 With SHIFT_SEQ_PARITY_EN defined, the last data shift SHALL enter PARITY instead of DONE.
- PARITY: one further bit period, ending in one shift_enable with output parity_slot=1.
- bit_count SHALL NOT increment on that shift; PARITY -> DONE.
- Without the macro, the parity_slot port and the PARITY state SHALL be absent.

Structure
REQ-028 Package shift_seq_pkg SHALL hold the state enum type and the default width constants.
REQ-029 The period counter SHALL be a sub-module named period_counter with these ports:
- inputs clk, n_rst, clear, count_enable, rollover_val;
- outputs count_out, rollover_flag.
- The FSM drives clear and count_enable.

Verification
REQ-030 Start with frame_len=8, bit_period=4, start at edge 0:
- load_enable in cycle 1;
- shift_enable in cycles 5,9,...,33;
- done in cycle 34; busy low from cycle 35.
REQ-031 Start with frame_len=3, bit_period=0: shifts in cycles 2,3,4; done in cycle 5.
REQ-032 Start with frame_len=0: no load_enable, busy stays 0.
REQ-033 abort in cycle 10 of the REQ-030 frame:
- IDLE in cycle 11, done never pulses.
- A new start then gives load_enable one cycle after acceptance.
- Variant: abort and start together in IDLE -> no frame starts.
REQ-034 n_rst low mid-WAIT: all outputs go to 0 at once, before the next clk edge.
REQ-035 Built with SHIFT_SEQ_PARITY_EN, rerun REQ-030:
- extra shift_enable with parity_slot=1 in cycle 37;
- done in cycle 38; bit_count stays 8.
